// File: rtl/mini_alu_arbiter_pkg.sv
// ============================================================================
//  Module      : mini_alu_pkg
//  Description : Shared widths and FSM state type for the miniALU arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mini_alu_pkg;

    localparam int ALU_IN_W  = 4;
    localparam int ALU_RES_W = 20;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } arb_state_t;

endpackage

`default_nettype wire

// File: rtl/mini_alu_arbiter_rr.sv
// ============================================================================
//  Module      : rr_arbiter
//  Description : Combinational round-robin picker. Grants the first asserted
//                request found searching upward from ptr_i with wrap-around.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  grant_o,
    output logic [IW-1:0] grant_idx_o,
    output logic          any_o
);

    // Walk the requests starting at the pointer; the first hit wins
    always_comb begin : p_pick
        logic found;
        int   idx;
        found       = 1'b0;
        idx         = 0;
        grant_o     = '0;
        grant_idx_o = '0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(ptr_i) + k) % N;
            if (!found && req_i[idx]) begin
                found        = 1'b1;
                grant_o[idx] = 1'b1;
                grant_idx_o  = IW'(idx);
            end
        end
        any_o = found;
    end

endmodule

`default_nettype wire

// File: rtl/mini_alu_arbiter.sv
// ============================================================================
//  Module      : mini_alu_arbiter
//  Description : Shares one combinational miniALU between NUM_REQ requesters.
//                Round-robin accept, registered operand launch, result capture
//                after ALU_LAT cycles, tagged valid/ready response channel.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mini_alu_arbiter
    import mini_alu_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ALU_LAT = 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid_i,
    output logic [NUM_REQ-1:0]            req_ready_o,
    input  logic [NUM_REQ*ALU_IN_W-1:0]   req_a_i,
    input  logic [NUM_REQ*ALU_IN_W-1:0]   req_b_i,
    input  logic [NUM_REQ-1:0]            req_op_i,
    output logic [ALU_IN_W-1:0]           alu_a_o,
    output logic [ALU_IN_W-1:0]           alu_b_o,
    output logic                          alu_op_o,
    input  logic [ALU_RES_W-1:0]          alu_result_i,
    output logic                          rsp_valid_o,
    input  logic                          rsp_ready_i,
    output logic [$clog2(NUM_REQ)-1:0]    rsp_id_o,
    output logic [ALU_RES_W-1:0]          rsp_result_o,
    output logic                          busy_o
);

    localparam int         IDW    = $clog2(NUM_REQ);
    localparam logic [2:0] LAT_M1 = 3'(ALU_LAT - 1);

    arb_state_t             state_q, state_d;
    logic [IDW-1:0]         ptr_q, ptr_d;
    logic [2:0]             cnt_q, cnt_d;
    logic [ALU_IN_W-1:0]    alu_a_q, alu_a_d;
    logic [ALU_IN_W-1:0]    alu_b_q, alu_b_d;
    logic                   alu_op_q, alu_op_d;
    logic [IDW-1:0]         rsp_id_q, rsp_id_d;
    logic [ALU_RES_W-1:0]   rsp_res_q, rsp_res_d;
    logic                   rsp_valid_q, rsp_valid_d;

    logic [NUM_REQ-1:0]     w_grant;
    logic [IDW-1:0]         w_grant_idx;
    logic                   w_grant_any;
    logic [ALU_IN_W-1:0]    w_sel_a;
    logic [ALU_IN_W-1:0]    w_sel_b;
    logic                   w_sel_op;

    rr_arbiter #(
        .N  (NUM_REQ),
        .IW (IDW)
    ) u_rr (
        .req_i       (req_valid_i),
        .ptr_i       (ptr_q),
        .grant_o     (w_grant),
        .grant_idx_o (w_grant_idx),
        .any_o       (w_grant_any)
    );

    // Route the granted requester's operands (grant is one-hot or zero)
    always_comb begin
        w_sel_a  = '0;
        w_sel_b  = '0;
        w_sel_op = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_grant[i]) begin
                w_sel_a  = req_a_i[i*ALU_IN_W +: ALU_IN_W];
                w_sel_b  = req_b_i[i*ALU_IN_W +: ALU_IN_W];
                w_sel_op = req_op_i[i];
            end
        end
    end

    // Next-state logic: accept in IDLE, count down in WAIT, hold in RESP
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        cnt_d       = cnt_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_op_d    = alu_op_q;
        rsp_id_d    = rsp_id_q;
        rsp_res_d   = rsp_res_q;
        rsp_valid_d = rsp_valid_q;
        req_ready_o = '0;
        case (state_q)
            IDLE: begin
                req_ready_o = w_grant;
                if (w_grant_any) begin
                    alu_a_d  = w_sel_a;
                    alu_b_d  = w_sel_b;
                    alu_op_d = w_sel_op;
                    rsp_id_d = w_grant_idx;
                    ptr_d    = (w_grant_idx == IDW'(NUM_REQ - 1)) ? '0
                                                                   : w_grant_idx + IDW'(1);
                    cnt_d    = LAT_M1;
                    state_d  = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q != 3'd0) begin
                    cnt_d = cnt_q - 3'd1;
                end else begin
                    rsp_res_d   = alu_result_i;
                    rsp_valid_d = 1'b1;
                    state_d     = RESP;
                end
            end
            RESP: begin
                if (rsp_ready_i) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset drops any in-flight operation
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            cnt_q       <= '0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_op_q    <= 1'b0;
            rsp_id_q    <= '0;
            rsp_res_q   <= '0;
            rsp_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            cnt_q       <= cnt_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_op_q    <= alu_op_d;
            rsp_id_q    <= rsp_id_d;
            rsp_res_q   <= rsp_res_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end

    assign alu_a_o      = alu_a_q;
    assign alu_b_o      = alu_b_q;
    assign alu_op_o     = alu_op_q;
    assign rsp_valid_o  = rsp_valid_q;
    assign rsp_id_o     = rsp_id_q;
    assign rsp_result_o = rsp_res_q;
    assign busy_o       = (state_q != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_mini_alu_arbiter.sv
// ============================================================================
//  Module      : tb_mini_alu_arbiter
//  Description : Self-checking bench for mini_alu_arbiter (ALU_LAT=1 main
//                instance with a cycle model, ALU_LAT=3 instance for latency).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mini_alu_arbiter;

    localparam int N = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst_n;
    logic [N-1:0]   req_valid, req_ready, req_op;
    logic [N*4-1:0] req_a, req_b;
    logic [3:0]     alu_a, alu_b;
    logic           alu_op;
    logic [19:0]    alu_result;
    logic           rsp_valid, rsp_ready;
    logic [1:0]     rsp_id;
    logic [19:0]    rsp_result;
    logic           busy;

    logic [N-1:0]   req_valid3, req_ready3, req_op3;
    logic [N*4-1:0] req_a3, req_b3;
    logic [3:0]     alu_a3, alu_b3;
    logic           alu_op3;
    logic [19:0]    alu_result3;
    logic           rsp_valid3, rsp_ready3;
    logic [1:0]     rsp_id3;
    logic [19:0]    rsp_result3;
    logic           busy3;
    logic           p3;

    // ALU stubs
    assign alu_result  = {11'b0, alu_op, alu_a, alu_b};
    assign alu_result3 = p3 ? 20'hFFFFF : {11'b0, alu_op3, alu_a3, alu_b3};

    mini_alu_arbiter #(.NUM_REQ(N), .ALU_LAT(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid_i(req_valid), .req_ready_o(req_ready),
        .req_a_i(req_a), .req_b_i(req_b), .req_op_i(req_op),
        .alu_a_o(alu_a), .alu_b_o(alu_b), .alu_op_o(alu_op),
        .alu_result_i(alu_result),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
        .rsp_id_o(rsp_id), .rsp_result_o(rsp_result), .busy_o(busy)
    );

    mini_alu_arbiter #(.NUM_REQ(N), .ALU_LAT(3)) dut3 (
        .clk(clk), .rst_n(rst_n),
        .req_valid_i(req_valid3), .req_ready_o(req_ready3),
        .req_a_i(req_a3), .req_b_i(req_b3), .req_op_i(req_op3),
        .alu_a_o(alu_a3), .alu_b_o(alu_b3), .alu_op_o(alu_op3),
        .alu_result_i(alu_result3),
        .rsp_valid_o(rsp_valid3), .rsp_ready_i(rsp_ready3),
        .rsp_id_o(rsp_id3), .rsp_result_o(rsp_result3), .busy_o(busy3)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    // First valid requester at or after p, wrapping; -1 if none
    function automatic int pick(input logic [N-1:0] v, input int p);
        for (int k = 0; k < N; k++) begin
            if (v[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    // ---------------- behavioural model of the ALU_LAT=1 instance -----------
    bit          m_on = 0;
    bit          m_busy, m_rsp;
    int          m_left, m_ptr, m_id;
    logic [3:0]  m_a, m_b;
    logic        m_op;
    logic [19:0] m_res;

    always @(posedge clk) begin
        int g;
        if (!rst_n) begin
            m_on = 1; m_busy = 0; m_rsp = 0; m_left = 0; m_ptr = 0; m_id = 0;
            m_a = '0; m_b = '0; m_op = 1'b0; m_res = '0;
        end else if (m_on) begin
            if (!m_busy) begin
                g = pick(req_valid, m_ptr);
                if (g >= 0) begin
                    m_a    = req_a[g*4 +: 4];
                    m_b    = req_b[g*4 +: 4];
                    m_op   = req_op[g];
                    m_id   = g;
                    m_ptr  = (g + 1) % N;
                    m_busy = 1;
                    m_left = 1;
                end
            end else if (!m_rsp) begin
                m_left--;
                if (m_left == 0) begin
                    m_res = {11'b0, m_op, m_a, m_b};
                    m_rsp = 1;
                end
            end else if (rsp_ready) begin
                m_rsp  = 0;
                m_busy = 0;
            end
        end
    end

    // Responses seen by the bench, in handshake order
    int          log_id[$];
    logic [19:0] log_res[$];

    // Per-cycle comparison of every output against the model
    always @(negedge clk) begin
        int          g;
        logic [N-1:0] exp_ready;
        if (m_on) begin
            g         = pick(req_valid, m_ptr);
            exp_ready = (!m_busy && g >= 0) ? N'(1 << g) : '0;
            check("req_ready", req_ready, exp_ready);
            check("alu_a", alu_a, m_a);
            check("alu_b", alu_b, m_b);
            check("alu_op", alu_op, m_op);
            check("busy", busy, m_busy);
            check("rsp_valid", rsp_valid, m_rsp);
            check("rsp_id", rsp_id, m_id);
            check("rsp_result", rsp_result, m_res);
            if (rsp_valid && rsp_ready) begin
                log_id.push_back(int'(rsp_id));
                log_res.push_back(rsp_result);
            end
        end
    end

    // ---------------- stimulus ----------------------------------------------
    // One clock; requesters drop valid after being accepted
    task automatic tick();
        logic [N-1:0] acc;
        @(negedge clk);
        acc = req_valid & req_ready;
        @(posedge clk);
        #1;
        if (rst_n) req_valid = req_valid & ~acc;
    endtask

    task automatic set_req(input int i, input int a, input int b, input int op);
        req_a[i*4 +: 4] = 4'(a);
        req_b[i*4 +: 4] = 4'(b);
        req_op[i]       = op[0];
        req_valid[i]    = 1'b1;
    endtask

    initial begin
        int base;
        rst_n = 0; req_valid = '0; req_a = '0; req_b = '0; req_op = '0; rsp_ready = 0;
        req_valid3 = '0; req_a3 = '0; req_b3 = '0; req_op3 = '0; rsp_ready3 = 0; p3 = 0;
        repeat (2) tick();
        check("rst_busy", busy, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_alu_a", alu_a, 0);
        check("rst_rsp_result", rsp_result, 0);
        check("rst_busy3", busy3, 0);
        rst_n = 1;

        // 1: single request from requester 1
        set_req(1, 3, 5, 1);
        rsp_ready = 1;
        #1;
        check("t1_ready", req_ready, 4'b0010);
        tick();
        check("t1_rv_wait", rsp_valid, 0);
        check("t1_busy", busy, 1);
        tick();
        check("t1_rv", rsp_valid, 1);
        check("t1_id", rsp_id, 1);
        check("t1_res", rsp_result, 20'h00135);
        tick();
        check("t1_idle", busy, 0);

        // 5: ALU_LAT=3 instance, stub corrupted until just before capture
        req_valid3 = 4'b0001; req_a3[3:0] = 4'd4; req_b3[3:0] = 4'd2; req_op3[0] = 1'b1;
        #1;
        check("t5_ready", req_ready3, 4'b0001);
        tick();
        req_valid3 = '0;
        p3 = 1;
        check("t5_rv_T", rsp_valid3, 0);
        tick();
        check("t5_rv_T1", rsp_valid3, 0);
        tick();
        check("t5_rv_T2", rsp_valid3, 0);
        p3 = 0;
        tick();
        check("t5_rv_T3", rsp_valid3, 1);
        check("t5_id", rsp_id3, 0);
        check("t5_res", rsp_result3, 20'h00142);
        rsp_ready3 = 1;
        tick();
        check("t5_rv_done", rsp_valid3, 0);
        rsp_ready3 = 0;

        // 2: all four valid from a fresh pointer
        rst_n = 0; tick(); rst_n = 1;
        base = log_id.size();
        for (int i = 0; i < N; i++) set_req(i, i, 15 - i, 0);
        repeat (14) tick();
        check("t2_count", log_id.size(), base + 4);
        for (int k = 0; k < 4; k++) begin
            check("t2_id", log_id[base + k], k);
            check("t2_res", log_res[base + k], 20'(k * 16 + (15 - k)));
        end

        // 3: pointer wrap 3 -> 0
        base = log_id.size();
        set_req(3, 7, 1, 1);
        tick();
        set_req(0, 2, 2, 0);
        set_req(3, 8, 1, 1);
        repeat (10) tick();
        check("t3_count", log_id.size(), base + 3);
        check("t3_id0", log_id[base], 3);
        check("t3_id1", log_id[base + 1], 0);
        check("t3_id2", log_id[base + 2], 3);
        check("t3_res0", log_res[base], 20'h00171);
        check("t3_res1", log_res[base + 1], 20'h00022);
        check("t3_res2", log_res[base + 2], 20'h00181);

        // 4: back-pressure on the response channel
        rsp_ready = 0;
        set_req(2, 9, 6, 0);
        tick();
        tick();
        check("t4_rv", rsp_valid, 1);
        set_req(0, 1, 1, 0);
        repeat (5) begin
            tick();
            check("t4_hold_rv", rsp_valid, 1);
            check("t4_hold_id", rsp_id, 2);
            check("t4_hold_res", rsp_result, 20'h00096);
            check("t4_ready0", req_ready, 4'b0000);
            check("t4_busy", busy, 1);
        end
        rsp_ready = 1;
        tick();
        check("t4_release_busy", busy, 0);
        check("t4_release_rv", rsp_valid, 0);
        repeat (4) tick();

        // 6: reset while waiting for the ALU
        set_req(1, 5, 10, 1);
        tick();
        check("t6_busy", busy, 1);
        rst_n = 0;
        tick();
        check("t6_busy0", busy, 0);
        check("t6_rv0", rsp_valid, 0);
        check("t6_alu_a0", alu_a, 0);
        check("t6_alu_b0", alu_b, 0);
        check("t6_alu_op0", alu_op, 0);
        check("t6_id0", rsp_id, 0);
        check("t6_res0", rsp_result, 0);
        rst_n = 1;
        base = log_id.size();
        repeat (4) tick();
        check("t6_no_rsp", log_id.size(), base);
        set_req(3, 6, 3, 0);
        repeat (4) tick();
        check("t6_count", log_id.size(), base + 1);
        check("t6_id", log_id[base], 3);
        check("t6_res", log_res[base], 20'h00063);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
